// File: rtl/reduction_stream_checker.sv
// reduction_stream_checker: assembles 16-bit words from nibble beats, computes reduction flags and checks them against expected flags.
module reduction_stream_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_nibble,
    input  logic [7:0] exp_flags,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_flags,
    output logic       out_mismatch,
    output logic [7:0] err_count
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [11:0] asm_q;
    logic [15:0] word_d;
    logic [7:0]  flags_d;
    // earlier nibbles shift in from the top, so the live nibble completes the word
    assign word_d = {in_nibble, asm_q};
    always_comb begin
        flags_d[0] = &word_d[15:8];
        flags_d[1] = |word_d[7:0];
        flags_d[2] = ^word_d[11:4];
        flags_d[3] = &word_d;
        flags_d[4] = |word_d;
        flags_d[5] = word_d[0] ^ word_d[4] ^ word_d[8] ^ word_d[12];
        flags_d[6] = (&word_d[7:0]) | (&word_d[15:8]);
        flags_d[7] = (^word_d[3:0]) & (|word_d[15:12]);
    end
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            cnt_q        <= 2'd0;
            asm_q        <= 12'd0;
            out_flags    <= 8'h00;
            out_mismatch <= 1'b0;
            err_count    <= 8'h00;
        end else if (clear) begin
            state_q <= COLLECT;
            cnt_q   <= 2'd0;
        end else if (state_q == COLLECT) begin
            if (in_valid) begin
                asm_q <= {in_nibble, asm_q[11:4]};
                cnt_q <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    out_flags    <= flags_d;
                    out_mismatch <= (flags_d != exp_flags);
                    state_q      <= HOLD;
                end
            end
        end else if (out_ready) begin
            state_q <= COLLECT;
            if (out_mismatch && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_reduction_stream_checker.sv
// tb_reduction_stream_checker: table-driven words with a result scoreboard, plus back-pressure, clear, saturation and async-reset sequences.
module tb_reduction_stream_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_nibble = 4'h0;
    logic [7:0] exp_flags = 8'h00;
    logic       clear = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_flags;
    logic       out_mismatch;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;
    int exp_err = 0;
    logic [8:0] sb_q[$];

    typedef struct {
        logic [15:0] word;
        logic [7:0]  exp;
        logic [7:0]  flags;
        logic        mm;
    } vec_t;
    vec_t tbl[10];

    reduction_stream_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_nibble(in_nibble), .exp_flags(exp_flags), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_flags(out_flags),
        .out_mismatch(out_mismatch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic odd(input logic [15:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c[0];
    endfunction

    function automatic logic [7:0] model(input logic [15:0] d);
        logic [15:0] tmp;
        logic [7:0] f;
        f[0] = (d[15:8] == 8'hFF);
        f[1] = (d[7:0] != 8'h00);
        tmp  = d >> 4;
        f[2] = odd(tmp, 8);
        f[3] = (d == 16'hFFFF);
        f[4] = (d != 16'h0000);
        tmp  = {12'd0, d[12], d[8], d[4], d[0]};
        f[5] = odd(tmp, 4);
        f[6] = (d[7:0] == 8'hFF) || (d[15:8] == 8'hFF);
        f[7] = odd(d, 4) && (d[15:12] != 4'h0);
        return f;
    endfunction

    // scoreboard: pop on each consuming handshake
    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", {7'd0, out_valid}, 16'd0);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("out_flags", {8'd0, out_flags}, {8'd0, e[8:1]});
                chk("out_mismatch", {15'd0, out_mismatch}, {15'd0, e[0]});
                if (e[0] && exp_err < 255) exp_err++;
            end
        end
    end

    task automatic beat(input logic [3:0] n, input logic [7:0] e);
        int t = 0;
        in_valid  = 1'b1;
        in_nibble = n;
        exp_flags = e;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) chk("beat_timeout", 16'd0, 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic [7:0] e, input logic [7:0] f, input logic mm);
        sb_q.push_back({f, mm});
        for (int b = 0; b < 4; b++) beat(w[b*4 +: 4], e);
        in_valid = 1'b0;
        chk("latency_out_valid", {15'd0, out_valid}, 16'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 16'(sb_q.size()), 16'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{16'hFFFF, 8'h5B, 8'h5B, 1'b0};
        tbl[1] = '{16'h1001, 8'h92, 8'h92, 1'b0};
        tbl[2] = '{16'h00FF, 8'h00, 8'h52, 1'b1};
        tbl[3] = '{16'h0000, 8'h00, 8'h00, 1'b0};
        for (int i = 4; i < 10; i++) begin
            logic [15:0] w;
            logic [7:0] e;
            w = 16'($urandom);
            e = (i % 2 == 0) ? model(w) : 8'($urandom);
            tbl[i] = '{w, e, model(w), model(w) != e};
        end

        #2;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_flags", {8'd0, out_flags}, 16'h0000);
        chk("rst_out_mismatch", {15'd0, out_mismatch}, 16'd0);
        chk("rst_err_count", {8'd0, err_count}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 10; i++) send_word(tbl[i].word, tbl[i].exp, tbl[i].flags, tbl[i].mm);
        drain();
        chk("err_after_table", {8'd0, err_count}, 16'(exp_err));

        // back-pressure: result held while out_ready low
        out_ready = 1'b0;
        send_word(16'h0000, 8'h00, 8'h00, 1'b0);
        in_valid  = 1'b1;
        in_nibble = 4'h5;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
            chk("bp_out_flags", {8'd0, out_flags}, 16'h0000);
            chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_released", {15'd0, in_ready}, 16'd1);

        // clear mid-word: two beats then clear with a beat presented
        beat(4'hA, 8'h00);
        beat(4'h3, 8'h00);
        clear = 1'b1;
        in_nibble = 4'h7;
        @(posedge clk);
        #1 clear = 1'b0;
        in_valid = 1'b0;
        send_word(16'hFFFF, 8'h5B, 8'h5B, 1'b0);
        drain();

        // clear in HOLD while consuming: pending mismatch result not counted
        out_ready = 1'b0;
        sb_q.push_back(9'd0);
        for (int b = 0; b < 4; b++) beat(4'hF, 8'h00);
        in_valid = 1'b0;
        void'(sb_q.pop_back());
        clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clear_hold_out_valid", {15'd0, out_valid}, 16'd0);
        chk("clear_hold_err", {8'd0, err_count}, 16'(exp_err));

        // saturation
        for (int i = 0; i < 260; i++) send_word(16'hFFFF, 8'h00, 8'h5B, 1'b1);
        drain();
        chk("err_saturated", {8'd0, err_count}, 16'd255);
        send_word(16'hFFFF, 8'h00, 8'h5B, 1'b1);
        drain();
        chk("err_held", {8'd0, err_count}, 16'd255);

        // asynchronous reset in HOLD
        out_ready = 1'b0;
        send_word(16'h1001, 8'h00, 8'h92, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("arst_err_count", {8'd0, err_count}, 16'd0);
        chk("arst_out_flags", {8'd0, out_flags}, 16'h0000);
        sb_q.delete();
        exp_err = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send_word(16'h00FF, 8'h00, 8'h52, 1'b1);
        drain();
        chk("post_reset_err", {8'd0, err_count}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
